// File: rtl/tile_scheduler.sv
// Layer-level tile sequencer: walks OFM channel groups (outer) and OFM rows (inner),
// issuing load / compute / store requests per tile and waiting for each done pulse.
module tile_scheduler #(
  parameter int TOTAL_PE = 16,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        KERNEL_W,
  input  logic [7:0]        OFM_W,
  input  logic [7:0]        OFM_C,
  input  logic [7:0]        IFM_C,
  input  logic [1:0]        stride,
  input  logic              load_done,
  input  logic              cal_done,
  input  logic              store_done,
  output logic              load_req,
  output logic              load_weight,
  output logic              cal_start,
  output logic              store_req,
  output logic [9:0]        ifm_row_base,
  output logic [7:0]        ofm_row,
  output logic [7:0]        ofm_ch_base,
  output logic [ADDR_W-1:0] weight_base_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_o
);

  localparam int PE_SH = $clog2(TOTAL_PE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CAL   = 3'd2,
    S_STORE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [7:0]        ofm_row_q;
  logic [7:0]        grp_q;
  logic [9:0]        ifm_base_q;
  logic [7:0]        ch_base_q;
  logic [ADDR_W-1:0] wbase_q;
  logic [7:0]        cfg_w;
  logic [1:0]        cfg_stride;
  logic [7:0]        num_grp_q;
  logic [23:0]       grp_bytes_q;
  logic              more_rows;
  logic              more_grps;

  // Only meaningful in NEXT, where cfg_w and num_grp_q are known to be non-zero.
  assign more_rows = (ofm_row_q < (cfg_w - 8'd1));
  assign more_grps = (grp_q < (num_grp_q - 8'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = ((OFM_W == 8'd0) || (OFM_C == 8'd0)) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:  if (load_done)  state_next = S_CAL;
      S_CAL:   if (cal_done)   state_next = S_STORE;
      S_STORE: if (store_done) state_next = S_NEXT;
      S_NEXT: begin
        if (more_rows || more_grps) state_next = S_LOAD;
        else                        state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Config is captured once per layer; only the derived quantities are kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ofm_row_q   <= '0;
      grp_q       <= '0;
      ifm_base_q  <= '0;
      ch_base_q   <= '0;
      wbase_q     <= '0;
      cfg_w       <= '0;
      cfg_stride  <= '0;
      num_grp_q   <= '0;
      grp_bytes_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_w       <= OFM_W;
            cfg_stride  <= (stride == 2'd0) ? 2'd1 : stride;
            num_grp_q   <= 8'((16'(OFM_C) + 16'(TOTAL_PE - 1)) >> PE_SH);
            grp_bytes_q <= 24'(KERNEL_W) * 24'(KERNEL_W) * 24'(IFM_C) * 24'(TOTAL_PE);
            ofm_row_q   <= '0;
            grp_q       <= '0;
            ifm_base_q  <= '0;
            ch_base_q   <= '0;
            wbase_q     <= '0;
          end
        end
        S_NEXT: begin
          if (more_rows) begin
            ofm_row_q  <= ofm_row_q + 8'd1;
            ifm_base_q <= ifm_base_q + 10'(cfg_stride);
          end else if (more_grps) begin
            ofm_row_q  <= '0;
            ifm_base_q <= '0;
            grp_q      <= grp_q + 8'd1;
            ch_base_q  <= ch_base_q + 8'(TOTAL_PE);
            wbase_q    <= wbase_q + ADDR_W'(grp_bytes_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign load_req         = (state == S_LOAD);
  assign load_weight      = (state == S_LOAD) && (ofm_row_q == 8'd0);
  assign cal_start        = (state == S_CAL);
  assign store_req        = (state == S_STORE);
  assign ifm_row_base     = ifm_base_q;
  assign ofm_row          = ofm_row_q;
  assign ofm_ch_base      = ch_base_q;
  assign weight_base_addr = wbase_q;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);
  assign state_o          = state;

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Sequences the conv datapath over one layer.
- Walks the OFM tile loop: outer loop over OFM channel groups of TOTAL_PE channels, inner loop over OFM rows.
- For each tile it issues load, compute and store requests in turn, and waits for each done pulse before moving on.
- Sits between the layer-level Control_unit (start/config) and the IFM/weight loaders, PE array and OFM store path.

Parameters:
TOTAL_PE, 16, OFM channels computed per tile (channel group size); power of two.
ADDR_W, 32, width of byte address outputs.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  single-cycle layer start; honoured only in IDLE.
KERNEL_W  in  4  kernel width/height (square).
OFM_W  in  8  OFM width = height (rows per group).
OFM_C  in  8  OFM channels.
IFM_C  in  8  IFM channels.
stride  in  2  conv stride; 0 treated as 1.
load_done  in  1  pulse: requested IFM rows (and weights if requested) loaded.
cal_done  in  1  pulse: PE array finished current tile.
store_done  in  1  pulse: OFM tile written.
load_req  out  1  high while in LOAD.
load_weight  out  1  valid with load_req; 1 when current tile needs a new weight group (row 0 of a group).
cal_start  out  1  high while in CAL.
store_req  out  1  high while in STORE.
ifm_row_base  out  10  first IFM row of tile = ofm_row*stride.
ofm_row  out  8  current OFM row.
ofm_ch_base  out  8  first OFM channel of current group = grp*TOTAL_PE.
weight_base_addr  out  ADDR_W  byte address of current weight group.
busy  out  1  high in every state except IDLE.
done  out  1  single-cycle pulse at layer end.
state_o  out  3  current state encoding.

Behaviour:
- States/encoding: IDLE=0, LOAD=1, CAL=2, STORE=3, NEXT=4, DONE=5. Outputs are Moore-decoded from the state and counter registers.
- Reset (rst_n low at a clock edge, any state):
  - State goes to IDLE; row and group counters, latched config and weight_base_addr go to 0.
  - All outputs are 0.
  - In-flight handshakes are abandoned; no done pulse is issued.
- IDLE:
  - On start, latch KERNEL_W, OFM_W, OFM_C, IFM_C, stride (0 latched as 1).
  - Compute num_grp = ceil(OFM_C/TOTAL_PE) and grp_bytes = K*K*IFM_C*TOTAL_PE (24-bit, zero-extended to ADDR_W).
  - Clear counters. Go to LOAD, or to DONE if OFM_W==0 or OFM_C==0.
- LOAD:
  - load_req=1; load_weight=(ofm_row==0).
  - On load_done go to CAL. The pulse is accepted even in the first LOAD cycle.
- CAL: cal_start=1; on cal_done go to STORE.
- STORE: store_req=1; on store_done go to NEXT.
- NEXT (one cycle):
  - If ofm_row < OFM_W-1: ofm_row+1, ifm_row_base+stride, go to LOAD.
  - Else if grp < num_grp-1: ofm_row=0, ifm_row_base=0, grp+1, ofm_ch_base+TOTAL_PE, weight_base_addr+grp_bytes, go to LOAD.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Input qualification:
  - Done pulses arriving in a non-matching state are ignored (no effect, no latching).
  - start while busy is ignored; config inputs are not re-sampled until IDLE.
- Timing: minimum tile period is 4 cycles (LOAD, CAL, STORE, NEXT with same-cycle dones). Total layer cycles with immediate dones = 1 + 4*OFM_W*num_grp + 1.
- Arithmetic widths:
  - ifm_row_base: 10-bit (max 254*3=762, no overflow).
  - ofm_ch_base: 8-bit; OFM_C≤255 bounds it.
  - weight_base_addr wraps modulo 2^ADDR_W.

Test Plan:
- Basic walk. Stimulus: TOTAL_PE=16, K=3, OFM_W=2, OFM_C=32, IFM_C=32, stride=2, all dones returned in the same cycle. Required: 4 tiles with (row, ch_base, ifm_row_base, weight_base) = (0,0,0,0), (1,0,2,0), (0,16,0,4608), (1,16,2,4608); load_weight=1 on tiles 1 and 3 only; done pulse at cycle 18 after start; busy falls after it.
- Partial group and stride 0. Stimulus: OFM_C=20, OFM_W=1, stride=0. Required: num_grp=2, ch_base 0 then 16; ifm_row_base always 0; stride behaves as 1.
- Stretched handshakes. Stimulus: load_done delayed 5 cycles, cal_done 10, store_done 3. Required: each req is held for exactly that many cycles plus the acceptance cycle; a stray cal_done during LOAD is ignored and state stays 1.
- Degenerate config. Stimulus: OFM_W=0. Required: IDLE→DONE→IDLE; done pulses once; load_req, cal_start and store_req never assert.
- Reset mid-operation. Stimulus: rst_n low for one edge while in CAL on tile 2. Required: next cycle state_o=0, all outputs 0, no done; a fresh start restarts from row 0, group 0.
- start while busy. Stimulus: second start pulse with a different OFM_W during STORE. Required: ignored; original tile count completes unchanged.
